// File: rtl/decoder_pkg.sv
// Shared code map for the 2-to-4 stream decoder; matches the 4-to-2 encoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        CODE_D = 2'b00,
        CODE_C = 2'b01,
        CODE_B = 2'b10,
        CODE_A = 2'b11
    } code_e;

    // Returns {a,b,c,d}; exactly one bit set for every code.
    function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
        logic [3:0] oh;
        oh = '0;
        case (code)
            CODE_A:  oh = 4'b1000;
            CODE_B:  oh = 4'b0100;
            CODE_C:  oh = 4'b0010;
            default: oh = 4'b0001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/decoder_2to4_stream_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head word is read combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; emptiness is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/decoder_2to4_stream.sv
// Streaming 2-to-4 decoder: buffered valid/ready codes out as one-hot a/b/c/d
// with saturating per-line delivery counters.
module decoder_2to4_stream
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             e1,
    input  logic             e0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);

    logic       full;
    logic       empty;
    logic [1:0] head;
    logic [3:0] onehot;
    logic       pop_fire;

    sync_fifo #(
        .WIDTH (2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata ({e1, e0}),
        .pop   (out_ready),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign in_ready     = !full;
    assign out_valid    = !empty;
    assign pop_fire     = out_valid && out_ready;
    assign onehot       = out_valid ? code_to_onehot(head) : '0;
    assign {a, b, c, d} = onehot;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // clr takes priority over a coincident pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
            cnt_d <= '0;
        end else if (clr) begin
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
            cnt_d <= '0;
        end else if (pop_fire) begin
            if (onehot[3]) cnt_a <= sat_inc(cnt_a);
            if (onehot[2]) cnt_b <= sat_inc(cnt_b);
            if (onehot[1]) cnt_c <= sat_inc(cnt_c);
            if (onehot[0]) cnt_d <= sat_inc(cnt_d);
        end
    end

endmodule

// File: doc/decoder_2to4_stream.md
# decoder_2to4_stream

Streaming 2-to-4 decoder: the receive-side counterpart of the team's 4-to-2 encoder. It accepts 2-bit codes {e1,e0} through a valid/ready handshake, buffers them in a small synchronous FIFO, and presents each code as a one-hot a/b/c/d word on a valid/ready output. It also keeps saturating per-line hit counters. It sits between an encoded link and consumers that need one-hot select lines.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- CNT_W, 8: width of each hit counter.

- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  code on e1/e0 is valid.
- in_ready  output  1  block can accept a code this cycle.
- e1  input  1  code bit 1.
- e0  input  1  code bit 0.
- out_valid  output  1  a/b/c/d carry a decoded code.
- out_ready  input  1  consumer accepts the current output.
- a, b, c, d  output  1 each  one-hot decoded lines.
- clr  input  1  synchronous clear of all hit counters.
- cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_W each  saturating count of codes delivered on each line.

## Operation
- Code map, fixed and matching the encoder: {e1,e0}=11 → a, 10 → b, 01 → c, 00 → d.
- Push: a code is written when in_valid & in_ready. in_ready = !full.
- Pop: a code is consumed when out_valid & out_ready. out_valid = !empty.
- Outputs:
  - a..d are the one-hot decode of the FIFO head while out_valid=1.
  - a..d are 4'b0000 while empty.
  - a..d never show more than one bit high.
- Full/empty tracking:
  - Read and write pointers are log2(DEPTH)+1 bits wide, so the extra MSB separates full from empty.
  - Pointers wrap modulo 2·DEPTH.
- Simultaneous push and pop:
  - When neither full nor empty, both happen in the same cycle and occupancy is unchanged.
  - When full, no push occurs because in_ready=0.
  - When empty, no pop occurs because out_valid=0. There is no bypass.
- Ordering: codes leave in arrival order. None are dropped or duplicated.
- Counters:
  - On a pop, the counter for the decoded line increments by 1.
  - Each counter saturates at 2^CNT_W−1 and does not wrap.
- clr:
  - Sets all four counters to 0 on the next edge.
  - If clr and a pop occur in the same cycle, clear wins and the counter is 0.
  - clr does not affect the FIFO.
- in_valid while full: the code is simply not accepted. The upstream side must hold it. No error flag exists.
- Reset (async, any time, including mid-transfer):
  - Pointers go to 0, so the FIFO is empty.
  - out_valid=0, in_ready=1, a..d=0, all cnt_*=0.
  - Buffered codes are discarded.

## Timing
- Latency: a code pushed at edge N is visible on a..d with out_valid=1 after edge N, i.e. in cycle N+1 when the FIFO was empty.
- Throughput: one code per cycle in steady state with out_ready=1.
- Output path:
  - in_ready and out_valid come from registered pointers only.
  - a..d come combinationally from the head storage word.
  - No combinational path from in_valid to out_valid, or from out_ready to in_ready.
- Counters update at the edge of the pop and are visible the following cycle.
- In the reset release cycle, in_ready=1 immediately.

## Structure
- Package decoder_pkg:
  - CODE_A=2'b11, CODE_B=2'b10, CODE_C=2'b01, CODE_D=2'b00.
  - A function code_to_onehot(2-bit) returning 4-bit {a,b,c,d}.
- Sub-module sync_fifo (params WIDTH=2, DEPTH) with push/pop/full/empty/head.
- The top level holds the handshake glue, decode and counters.

## Test plan
- Reset then single push of 11 → next cycle out_valid=1, {a,b,c,d}=1000. Pop → cnt_a=1, out_valid=0, outputs 0000.
- Push 00,01,10,11 with out_ready=0 and DEPTH=4 → in_ready=0 after the 4th push. Release out_ready → outputs 0001, 0010, 0100, 1000 in order. Counts are all 1.
- Full FIFO with in_valid held and out_ready=1 for one cycle → exactly one pop, then one push the next cycle. Occupancy returns to 4 and no code is lost.
- CNT_W=2, pop 5 codes of 10 → cnt_b=3 (saturated). clr together with a 6th pop → cnt_b=0.
- Assert rst mid-stream with 3 entries buffered → asynchronously out_valid=0, a..d=0000, counters 0, in_ready=1. The first post-reset push decodes correctly.
- Random push/pop for 10k cycles against a reference queue model → order preserved, one-hot invariant holds, and counts match the model.
